// File: rtl/cd_pkg.sv
// cd_pkg: definitions shared by the CDBUS SPI-to-CSR bridge.
//   - cd_state_e : bridge transaction state (IDLE, CMD, WR, RD)
//   - CMD_WR_BIT / CMD_INC_BIT : bit positions inside the SPI command byte
//   - CSR_AW / CSR_DW : CSR bus address and data widths
package cd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } cd_state_e;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_INC_BIT = 6;

  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;

endpackage

// File: rtl/cd_sync.sv
// cd_sync: N-stage single-bit synchroniser for signals arriving from another
// clock domain (or from pins).
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset; every stage clears to 0
//   i_d     - asynchronous input
//   o_q     - synchronised output, STAGES clk cycles behind i_d
// Parameters:
//   STAGES  - number of flip-flops in the chain (2 or more)
module cd_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cd_spi_bridge.sv
// cd_spi_bridge: SPI mode-0 slave that turns host transactions into
// single-cycle read/write strobes on the CDBUS controller CSR bus.
//
// First byte after nss falls is a command: bit7 = write, bit6 = auto-increment,
// bits4:0 = address. Following bytes are written to (or read from) that
// address, one CSR strobe per complete byte.
//
// Optional feature macro: CD_SPI_AUTO_INC_EN
//   defined   - command bit6 makes the address step after every strobe
//   undefined - bit6 is ignored, the address stays fixed for the transaction
//
// Ports:
//   clk, reset_n   - system clock, asynchronous active-low reset
//   sck, nss, sdi  - SPI pins from the host (asynchronous to clk)
//   sdo, sdo_oe    - SPI data to the host and its output enable
//   csr_address    - CSR address (held, or stepping with auto-increment)
//   csr_read       - one-cycle read strobe, issued when a data byte has been
//                    fully shifted out
//   csr_readdata   - combinational CSR read data for csr_address
//   csr_write      - one-cycle write strobe
//   csr_writedata  - byte received from the host
// Parameters:
//   SYNC_STAGES    - synchroniser depth for sck/nss/sdi (2 or 3)
module cd_spi_bridge
  import cd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              nss,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [CSR_AW-1:0] csr_address,
  output logic              csr_read,
  input  logic [CSR_DW-1:0] csr_readdata,
  output logic              csr_write,
  output logic [CSR_DW-1:0] csr_writedata
);

  // ---------------------------------------------------------------- sync
  logic w_sck_s;
  logic w_nss_s;
  logic w_sdi_s;

  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (sck),
    .o_q     (w_sck_s)
  );

  // nss syncs to 0 out of reset: a falling edge can then only be seen after
  // the pin has genuinely been high, so a reset in the middle of a
  // transaction cannot restart it.
  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (nss),
    .o_q     (w_nss_s)
  );

  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (sdi),
    .o_q     (w_sdi_s)
  );

  // ---------------------------------------------------------- edge detect
  logic r_sck_d;
  logic r_nss_d;
  logic r_armed;   // set once synchronised nss has been high since reset

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_nss_rise;
  logic w_nss_fall;

  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_nss_rise = w_nss_s & ~r_nss_d;
  assign w_nss_fall = ~w_nss_s & r_nss_d;

  // ---------------------------------------------------------- datapath regs
  cd_state_e         r_state;
  cd_state_e         w_state_next;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_rx_shift;
  logic [CSR_DW-1:0] r_tx_shift;
  logic [CSR_AW-1:0] r_address;
  logic              r_inc;
  logic              r_csr_write;
  logic [CSR_DW-1:0] r_csr_writedata;
  logic              r_load_tx;

  logic [CSR_DW-1:0] w_rx_byte;
  logic              w_byte_done;
  logic              w_cmd_done;
  logic              w_csr_read;
  logic              w_write_next;
  logic              w_load_next;

  // Byte as it will look once the current sdi bit is shifted in.
  assign w_rx_byte = {r_rx_shift, w_sdi_s};

  // An nss rise in the same cycle as the 8th sck rise discards the byte.
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7) & ~w_nss_rise;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    w_cmd_done   = 1'b0;
    w_csr_read   = 1'b0;
    w_write_next = 1'b0;
    w_load_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nss_fall) begin
          w_state_next = CMD;
        end
      end
      CMD: begin
        if (w_byte_done) begin
          w_cmd_done = 1'b1;
          if (w_rx_byte[CMD_WR_BIT]) begin
            w_state_next = WR;
          end else begin
            // Preload the first read byte; no CSR read for the command byte.
            w_state_next = RD;
            w_load_next  = 1'b1;
          end
        end
      end
      WR: begin
        w_write_next = w_byte_done;
      end
      RD: begin
        // The read strobe pops FIFO-style registers only for bytes that were
        // actually clocked out; the next byte is fetched a cycle later.
        w_csr_read  = w_byte_done;
        w_load_next = w_byte_done;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_nss_rise) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_sck_d         <= 1'b0;
      r_nss_d         <= 1'b0;
      r_armed         <= 1'b0;
      r_bit_cnt       <= 3'd0;
      r_rx_shift      <= 7'd0;
      r_tx_shift      <= '0;
      r_address       <= '0;
      r_inc           <= 1'b0;
      r_csr_write     <= 1'b0;
      r_csr_writedata <= '0;
      r_load_tx       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sck_d <= w_sck_s;
      r_nss_d <= w_nss_s;
      if (w_nss_s) begin
        r_armed <= 1'b1;
      end

      if (w_state_next == IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_sck_rise) begin
        r_rx_shift <= w_rx_byte[6:0];
      end

      if (w_cmd_done) begin
        r_address <= w_rx_byte[CSR_AW-1:0];
`ifdef CD_SPI_AUTO_INC_EN
        r_inc     <= w_rx_byte[CMD_INC_BIT];
`else
        r_inc     <= 1'b0;
`endif
      end else if (r_inc && (w_csr_read || r_csr_write)) begin
        // Step after the strobe so the strobe itself sees the old address;
        // wraps naturally at 5 bits.
        r_address <= r_address + 5'd1;
      end

      r_csr_write <= w_write_next;
      if (w_write_next) begin
        r_csr_writedata <= w_rx_byte;
      end

      r_load_tx <= w_load_next;
      if (r_load_tx) begin
        r_tx_shift <= csr_readdata;
      end else if ((r_state == RD) && w_sck_fall && (r_bit_cnt != 3'd0)) begin
        // The fall right after a byte boundary must not shift: bit 7 of the
        // freshly loaded byte has to stay on sdo for the next rising edge.
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign sdo_oe        = r_armed & ~w_nss_s;
  assign sdo           = sdo_oe & r_tx_shift[7];
  assign csr_address   = r_address;
  assign csr_read      = w_csr_read;
  assign csr_write     = r_csr_write;
  assign csr_writedata = r_csr_writedata;

endmodule

// File: tb/tb_cd_spi_bridge.sv
// Testbench for cd_spi_bridge: drives SPI mode-0 transactions and checks the
// CSR strobes against an expected-event queue, plus read-back data on sdo.
module tb_cd_spi_bridge;

  localparam int HP = 8;   // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sck = 1'b0;
  logic       nss = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       sdo_oe;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  logic [7:0] mem [32];

  assign csr_readdata = mem[csr_address];

  always #5 clk = ~clk;

  cd_spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sck           (sck),
    .nss           (nss),
    .sdi           (sdi),
    .sdo           (sdo),
    .sdo_oe        (sdo_oe),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata)
  );

  typedef struct packed {
    logic       is_wr;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  done     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic finish_sim();
    if (!done) begin
      done = 1;
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
    end
  endtask

  // Monitor: every CSR strobe is matched against the head of the queue.
  always @(negedge clk) begin
    if (reset_n && (csr_read || csr_write)) begin
      if (csr_read && csr_write) begin
        check("rw_exclusive", 32'(csr_read & csr_write), 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", {22'd0, csr_write, csr_address, csr_writedata}, 32'h0);
        if (!(csr_write == 1'b0 && csr_address == 5'd0 && csr_writedata == 8'd0)) begin
          // already counted above when non-zero; a zero-valued read still
          // needs flagging
        end else begin
          n_fail++;
          $display("FAIL unexpected_strobe: got read at 0x00, expected none");
        end
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        $display("strobe %s addr=0x%02h data=0x%02h", csr_write ? "WR" : "RD",
                 csr_address, csr_write ? csr_writedata : csr_readdata);
        check("strobe_kind", 32'(csr_write), 32'(e.is_wr));
        check("strobe_addr", 32'(csr_address), 32'(e.addr));
        if (e.is_wr) begin
          check("strobe_wdata", 32'(csr_writedata), 32'(e.data));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = b[i];
      wait_clk(HP);
      t[i] = sdo;
      sck = 1'b1;
      wait_clk(HP);
      sck = 1'b0;
    end
    r = t;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic nss_low();
    nss = 1'b0;
    wait_clk(HP);
  endtask

  task automatic nss_high();
    wait_clk(HP);
    nss = 1'b1;
    wait_clk(2 * HP);
  endtask

  task automatic push(input logic is_wr, input logic [4:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    wait_clk(4);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},   32'(csr_address),   32'd0);
    check({tag, "_read"},   32'(csr_read),      32'd0);
    check({tag, "_write"},  32'(csr_write),     32'd0);
    check({tag, "_wdata"},  32'(csr_writedata), 32'd0);
    check({tag, "_sdo"},    32'(sdo),           32'd0);
    check({tag, "_sdo_oe"}, 32'(sdo_oe),        32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 3 + 1);
    mem[0] = 8'h0d;
    mem[3] = 8'ha5;
    mem[7] = 8'h3c;

    // Reset state
    wait_clk(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clk(2 * HP);

    // Single write: 0x82, 0x55
    push(1'b1, 5'h02, 8'h55);
    nss_low();
    spi_byte(8'h82, rx);
    spi_byte(8'h55, rx);
    nss_high();
    check_drained("single_write_count");

    // Single read of address 0
    push(1'b0, 5'h00, 8'h00);
    nss_low();
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    check("single_read_sdo", 32'(rx), 32'h0d);
    nss_high();
    check_drained("single_read_count");

    // Streaming read of address 7, two bytes
    push(1'b0, 5'h07, 8'h00);
    push(1'b0, 5'h07, 8'h00);
    nss_low();
    spi_byte(8'h07, rx);
    spi_byte(8'h00, rx);
    check("stream_read_b0", 32'(rx), 32'h3c);
    spi_byte(8'h00, rx);
    check("stream_read_b1", 32'(rx), 32'h3c);
    nss_high();
    check_drained("stream_read_count");

    // TX stream to 0x15
    push(1'b1, 5'h15, 8'h11);
    push(1'b1, 5'h15, 8'h22);
    push(1'b1, 5'h15, 8'h33);
    nss_low();
    spi_byte(8'h95, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    nss_high();
    check("stream_addr_hold", 32'(csr_address), 32'h15);
    check_drained("stream_write_count");

    // Abort after 4 bits, then a clean write
    nss_low();
    spi_byte(8'h84, rx);
    spi_bits(8'haa, 4, rx);
    nss_high();
    check_drained("abort_no_write");
    push(1'b1, 5'h04, 8'h0b);
    nss_low();
    spi_byte(8'h84, rx);
    spi_byte(8'h0b, rx);
    nss_high();
    check_drained("after_abort_count");

    // Auto-increment command with wrap
`ifdef CD_SPI_AUTO_INC_EN
    push(1'b1, 5'h1f, 8'h01);
    push(1'b1, 5'h00, 8'h02);
`else
    push(1'b1, 5'h1f, 8'h01);
    push(1'b1, 5'h1f, 8'h02);
`endif
    nss_low();
    spi_byte(8'hdf, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h02, rx);
    nss_high();
    check_drained("auto_inc_count");

    // Reset in the middle of the second data byte of a read
    push(1'b0, 5'h03, 8'h00);
    nss_low();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    check("pre_reset_read_sdo", 32'(rx), 32'ha5);
    spi_bits(8'h00, 4, rx);
    reset_n = 1'b0;
    wait_clk(3);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    wait_clk(HP);
    spi_byte(8'h00, rx);   // nss still low: must be ignored
    check("post_reset_sdo_oe", 32'(sdo_oe), 32'd0);
    nss_high();
    check_drained("post_reset_no_read");
    push(1'b0, 5'h03, 8'h00);
    nss_low();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    check("recovered_read_sdo", 32'(rx), 32'ha5);
    nss_high();
    check_drained("recovered_read_count");

    finish_sim();
  end

  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    finish_sim();
  end

endmodule
